// File: rtl/alu_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct encodings and the
// instruction decode helper used by the decode/issue stage.
package alu_pkg;

    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [SEL_W-1:0] ALU_ADDU  = 4'd1;
    localparam logic [SEL_W-1:0] ALU_SUB   = 4'd2;
    localparam logic [SEL_W-1:0] ALU_SUBU  = 4'd3;
    localparam logic [SEL_W-1:0] ALU_AND   = 4'd4;
    localparam logic [SEL_W-1:0] ALU_OR    = 4'd5;
    localparam logic [SEL_W-1:0] ALU_XOR   = 4'd6;
    localparam logic [SEL_W-1:0] ALU_SLT_U = 4'd7;
    localparam logic [SEL_W-1:0] ALU_SLT_S = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_kind_e;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             illegal;
        imm_kind_e        imm_kind;
        logic             dest_is_rt;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d.sel        = ALU_AND;
        d.illegal    = 1'b0;
        d.imm_kind   = IMM_NONE;
        d.dest_is_rt = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADD:  d.sel = ALU_ADD;
                    FN_ADDU: d.sel = ALU_ADDU;
                    FN_SUB:  d.sel = ALU_SUB;
                    FN_SUBU: d.sel = ALU_SUBU;
                    FN_AND:  d.sel = ALU_AND;
                    FN_OR:   d.sel = ALU_OR;
                    FN_XOR:  d.sel = ALU_XOR;
                    FN_SLT:  d.sel = ALU_SLT_S;
                    FN_SLTU: d.sel = ALU_SLT_U;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin d.sel = ALU_ADD;   d.imm_kind = IMM_SEXT; d.dest_is_rt = 1'b1; end
            OP_ADDIU: begin d.sel = ALU_ADDU;  d.imm_kind = IMM_SEXT; d.dest_is_rt = 1'b1; end
            OP_SLTI:  begin d.sel = ALU_SLT_S; d.imm_kind = IMM_SEXT; d.dest_is_rt = 1'b1; end
            OP_SLTIU: begin d.sel = ALU_SLT_U; d.imm_kind = IMM_SEXT; d.dest_is_rt = 1'b1; end
            OP_ANDI:  begin d.sel = ALU_AND;   d.imm_kind = IMM_ZEXT; d.dest_is_rt = 1'b1; end
            OP_ORI:   begin d.sel = ALU_OR;    d.imm_kind = IMM_ZEXT; d.dest_is_rt = 1'b1; end
            OP_XORI:  begin d.sel = ALU_XOR;   d.imm_kind = IMM_ZEXT; d.dest_is_rt = 1'b1; end
            default:  d.illegal = 1'b1;
        endcase
        // Unsupported encodings fall back to AND with no immediate.
        if (d.illegal) begin
            d.sel      = ALU_AND;
            d.imm_kind = IMM_NONE;
        end else begin
            d.sel      = d.sel;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand source select for one register: zero register, EX/MEM bypass,
// MEM/WB bypass, or register-file data, in that priority.
module fwd_mux #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       src_reg_i,
    input  logic [WIDTH-1:0] rf_data_i,
    input  logic             exm_wr_en_i,
    input  logic [4:0]       exm_wr_reg_i,
    input  logic [WIDTH-1:0] exm_wr_data_i,
    input  logic             exm_is_load_i,
    input  logic             mwb_wr_en_i,
    input  logic [4:0]       mwb_wr_reg_i,
    input  logic [WIDTH-1:0] mwb_wr_data_i,
    output logic [WIDTH-1:0] fwd_data_o
);

    // Load results in EX/MEM are not ready yet, so they are never bypassed.
    always_comb begin
        fwd_data_o = rf_data_i;
        if (src_reg_i == 5'd0) begin
            fwd_data_o = {WIDTH{1'b0}};
        end else if (exm_wr_en_i && (exm_wr_reg_i == src_reg_i) && !exm_is_load_i) begin
            fwd_data_o = exm_wr_data_i;
        end else if (mwb_wr_en_i && (mwb_wr_reg_i == src_reg_i)) begin
            fwd_data_o = mwb_wr_data_i;
        end else begin
            fwd_data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue register feeding the ALU: decodes the select code, extends
// immediates, resolves forwarding, stalls on load-use and honours flush.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             exm_wr_en,
    input  logic [4:0]       exm_wr_reg,
    input  logic [WIDTH-1:0] exm_wr_data,
    input  logic             exm_is_load,
    input  logic             mwb_wr_en,
    input  logic [4:0]       mwb_wr_reg,
    input  logic [WIDTH-1:0] mwb_wr_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [SEL_W-1:0] ex_alu_sel,
    output logic             ex_wr_en,
    output logic [4:0]       ex_wr_reg,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] hazard_cnt
);

    import alu_pkg::*;

    dec_t             dec_s;
    logic [4:0]       rs_idx_s;
    logic [4:0]       rt_idx_s;
    logic [4:0]       dest_s;
    logic [WIDTH-1:0] imm_ext_s;
    logic [WIDTH-1:0] rs_fwd_s;
    logic [WIDTH-1:0] rt_fwd_s;
    logic [WIDTH-1:0] b_s;
    logic             wr_en_s;
    logic             is_rtype_s;
    logic             hazard_s;
    logic             capture_s;

    logic             ex_valid_q,   ex_valid_d;
    logic [WIDTH-1:0] ex_a_q,       ex_a_d;
    logic [WIDTH-1:0] ex_b_q,       ex_b_d;
    logic [SEL_W-1:0] ex_sel_q,     ex_sel_d;
    logic             ex_wr_en_q,   ex_wr_en_d;
    logic [4:0]       ex_wr_reg_q,  ex_wr_reg_d;
    logic             ex_illegal_q, ex_illegal_d;
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs (
        .src_reg_i     (rs_idx_s),
        .rf_data_i     (rs_data),
        .exm_wr_en_i   (exm_wr_en),
        .exm_wr_reg_i  (exm_wr_reg),
        .exm_wr_data_i (exm_wr_data),
        .exm_is_load_i (exm_is_load),
        .mwb_wr_en_i   (mwb_wr_en),
        .mwb_wr_reg_i  (mwb_wr_reg),
        .mwb_wr_data_i (mwb_wr_data),
        .fwd_data_o    (rs_fwd_s)
    );

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_rt (
        .src_reg_i     (rt_idx_s),
        .rf_data_i     (rt_data),
        .exm_wr_en_i   (exm_wr_en),
        .exm_wr_reg_i  (exm_wr_reg),
        .exm_wr_data_i (exm_wr_data),
        .exm_is_load_i (exm_is_load),
        .mwb_wr_en_i   (mwb_wr_en),
        .mwb_wr_reg_i  (mwb_wr_reg),
        .mwb_wr_data_i (mwb_wr_data),
        .fwd_data_o    (rt_fwd_s)
    );

    // Decode, immediate extension, destination and load-use hazard detection.
    always_comb begin
        dec_s      = decode_instr(id_instr);
        rs_idx_s   = id_instr[25:21];
        rt_idx_s   = id_instr[20:16];
        is_rtype_s = (id_instr[31:26] == OP_RTYPE);
        case (dec_s.imm_kind)
            IMM_SEXT: imm_ext_s = {{(WIDTH-16){id_instr[15]}}, id_instr[15:0]};
            IMM_ZEXT: imm_ext_s = {{(WIDTH-16){1'b0}}, id_instr[15:0]};
            default:  imm_ext_s = {WIDTH{1'b0}};
        endcase
        // Illegal encodings carry no destination at all.
        if (dec_s.illegal) begin
            dest_s = 5'd0;
        end else if (dec_s.dest_is_rt) begin
            dest_s = id_instr[20:16];
        end else begin
            dest_s = id_instr[15:11];
        end
        b_s       = (dec_s.imm_kind == IMM_NONE) ? rt_fwd_s : imm_ext_s;
        wr_en_s   = !dec_s.illegal && (dest_s != 5'd0);
        hazard_s  = id_valid && exm_is_load && exm_wr_en && (exm_wr_reg != 5'd0) &&
                    ((exm_wr_reg == rs_idx_s) || (is_rtype_s && (exm_wr_reg == rt_idx_s)));
        id_ready  = (!ex_valid_q || ex_ready) && !hazard_s && !flush;
        capture_s = id_valid && id_ready;
    end

    // Next-state for the issue register and the saturating stall counter.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_sel_d     = ex_sel_q;
        ex_wr_en_d   = ex_wr_en_q;
        ex_wr_reg_d  = ex_wr_reg_q;
        ex_illegal_d = ex_illegal_q;
        hazard_cnt_d = hazard_cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture_s) begin
            ex_valid_d   = 1'b1;
            ex_a_d       = rs_fwd_s;
            ex_b_d       = b_s;
            ex_sel_d     = dec_s.sel;
            ex_wr_en_d   = wr_en_s;
            ex_wr_reg_d  = dest_s;
            ex_illegal_d = dec_s.illegal;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
        if (hazard_s && !flush && (hazard_cnt_q != {CNT_W{1'b1}})) begin
            hazard_cnt_d = hazard_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hazard_cnt_d = hazard_cnt_q;
        end
    end

    // State registers; reset discards any in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_a_q       <= {WIDTH{1'b0}};
            ex_b_q       <= {WIDTH{1'b0}};
            ex_sel_q     <= {SEL_W{1'b0}};
            ex_wr_en_q   <= 1'b0;
            ex_wr_reg_q  <= 5'd0;
            ex_illegal_q <= 1'b0;
            hazard_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_sel_q     <= ex_sel_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_wr_reg_q  <= ex_wr_reg_d;
            ex_illegal_q <= ex_illegal_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_a       = ex_a_q;
    assign ex_b       = ex_b_q;
    assign ex_alu_sel = ex_sel_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign ex_wr_reg  = ex_wr_reg_q;
    assign ex_illegal = ex_illegal_q;
    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected ALU
// issue records; a monitor pops and compares on every ex_valid/ex_ready transfer.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        exm_wr_en;
    logic [4:0]  exm_wr_reg;
    logic [31:0] exm_wr_data;
    logic        exm_is_load;
    logic        mwb_wr_en;
    logic [4:0]  mwb_wr_reg;
    logic [31:0] mwb_wr_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_alu_sel;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_reg;
    logic        ex_illegal;
    logic [15:0] hazard_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .rs_data(rs_data), .rt_data(rt_data),
        .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_wr_data(exm_wr_data),
        .exm_is_load(exm_is_load), .mwb_wr_en(mwb_wr_en), .mwb_wr_reg(mwb_wr_reg),
        .mwb_wr_data(mwb_wr_data), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_sel(ex_alu_sel),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_illegal(ex_illegal),
        .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                                input logic we, input logic [4:0] rg, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.wr_en = we; e.wr_reg = rg; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs_v,
                         input logic [31:0] rt_v, input exp_t e);
        id_instr = instr;
        rs_data  = rs_v;
        rt_data  = rt_v;
        id_valid = 1'b1;
        sb_q.push_back(e);
        #1;
        chk("id_ready_on_issue", {31'd0, id_ready}, 32'd1);
        step();
        id_valid = 1'b0;
    endtask

    // Monitor: every accepted ALU transfer must match the oldest expectation.
    always @(negedge clk) begin
        exp_t act_v;
        exp_t e;
        if (rst_n && ex_valid && ex_ready) begin
            act_v.a = ex_a; act_v.b = ex_b; act_v.sel = ex_alu_sel;
            act_v.wr_en = ex_wr_en; act_v.wr_reg = ex_wr_reg; act_v.ill = ex_illegal;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transfer: got %h expected nothing", act_v);
            end else begin
                e = sb_q.pop_front();
                if (act_v !== e) begin
                    errors++;
                    $display("FAIL transfer: got a=%h b=%h sel=%0d we=%0b rd=%0d ill=%0b expected a=%h b=%h sel=%0d we=%0b rd=%0d ill=%0b",
                             act_v.a, act_v.b, act_v.sel, act_v.wr_en, act_v.wr_reg, act_v.ill,
                             e.a, e.b, e.sel, e.wr_en, e.wr_reg, e.ill);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        exm_wr_en = 1'b0; exm_wr_reg = 5'd0; exm_wr_data = 32'd0; exm_is_load = 1'b0;
        mwb_wr_en = 1'b0; mwb_wr_reg = 5'd0; mwb_wr_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        #3;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_b", ex_b, 32'd0);
        chk("rst_misc", {20'd0, ex_alu_sel, ex_wr_en, ex_wr_reg, ex_illegal}, 32'd0);
        chk("rst_hazard_cnt", {16'd0, hazard_cnt}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, mk(32'd5, 32'd7, 4'd0, 1'b1, 5'd3, 1'b0));
        chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        issue(itype(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'h12345678, 32'hDEAD0000,
              mk(32'h12345678, 32'h0000FFFF, 4'd4, 1'b1, 5'd4, 1'b0));
        issue(itype(6'h0A, 5'd1, 5'd4, 16'hFFFF), 32'h12345678, 32'hDEAD0000,
              mk(32'h12345678, 32'hFFFFFFFF, 4'd8, 1'b1, 5'd4, 1'b0));
        issue(itype(6'h0B, 5'd1, 5'd5, 16'h8000), 32'd9, 32'd0, mk(32'd9, 32'hFFFF8000, 4'd7, 1'b1, 5'd5, 1'b0));
        issue(rtype(5'd1, 5'd2, 5'd6, 6'h2B), 32'd3, 32'd4, mk(32'd3, 32'd4, 4'd7, 1'b1, 5'd6, 1'b0));
        issue(rtype(5'd1, 5'd2, 5'd6, 6'h2A), 32'd3, 32'd4, mk(32'd3, 32'd4, 4'd8, 1'b1, 5'd6, 1'b0));
        issue(rtype(5'd1, 5'd2, 5'd7, 6'h22), 32'd8, 32'd2, mk(32'd8, 32'd2, 4'd2, 1'b1, 5'd7, 1'b0));
        issue(itype(6'h0D, 5'd2, 5'd7, 16'h8001), 32'h100, 32'd0, mk(32'h100, 32'h00008001, 4'd5, 1'b1, 5'd7, 1'b0));
        issue(itype(6'h0E, 5'd2, 5'd8, 16'h00F0), 32'h1, 32'd0, mk(32'h1, 32'h000000F0, 4'd6, 1'b1, 5'd8, 1'b0));
        issue(itype(6'h09, 5'd2, 5'd8, 16'hFFFE), 32'h1, 32'd0, mk(32'h1, 32'hFFFFFFFE, 4'd1, 1'b1, 5'd8, 1'b0));
        issue(itype(6'h08, 5'd1, 5'd0, 16'h0005), 32'd10, 32'd0, mk(32'd10, 32'd5, 4'd0, 1'b0, 5'd0, 1'b0));
        issue(rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'd1, 32'd2, mk(32'd1, 32'd2, 4'd0, 1'b0, 5'd0, 1'b0));

        exm_wr_en = 1'b1; exm_wr_reg = 5'd1; exm_wr_data = 32'hAA;
        mwb_wr_en = 1'b1; mwb_wr_reg = 5'd1; mwb_wr_data = 32'hBB;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, mk(32'hAA, 32'd7, 4'd0, 1'b1, 5'd3, 1'b0));
        exm_wr_en = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, mk(32'hBB, 32'd7, 4'd0, 1'b1, 5'd3, 1'b0));
        exm_wr_en = 1'b1; exm_wr_reg = 5'd0; mwb_wr_reg = 5'd0;
        issue(rtype(5'd0, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, mk(32'd0, 32'd7, 4'd0, 1'b1, 5'd3, 1'b0));
        exm_wr_en = 1'b0; mwb_wr_reg = 5'd1;
        issue(rtype(5'd0, 5'd1, 5'd3, 6'h20), 32'd5, 32'd7, mk(32'd0, 32'hBB, 4'd0, 1'b1, 5'd3, 1'b0));
        mwb_wr_en = 1'b0;

        issue(rtype(5'd1, 5'd2, 5'd5, 6'h27), 32'd1, 32'd2, mk(32'd1, 32'd2, 4'd4, 1'b0, 5'd0, 1'b1));
        issue(itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'h11, 32'h22, mk(32'h11, 32'h22, 4'd4, 1'b0, 5'd0, 1'b1));

        // Load-use on rt of an R-type: two stall cycles, then issue with MEM/WB data.
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_wr_reg = 5'd2; exm_wr_data = 32'hEE;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); rs_data = 32'd5; rt_data = 32'd7; id_valid = 1'b1;
        sb_q.push_back(mk(32'd5, 32'h77, 4'd0, 1'b1, 5'd3, 1'b0));
        #1;
        chk("stall_ready_c0", {31'd0, id_ready}, 32'd0);
        step();
        #1;
        chk("stall_ready_c1", {31'd0, id_ready}, 32'd0);
        chk("stall_cnt_1", {16'd0, hazard_cnt}, 32'd1);
        step();
        exm_is_load = 1'b0; exm_wr_en = 1'b0;
        mwb_wr_en = 1'b1; mwb_wr_reg = 5'd2; mwb_wr_data = 32'h77;
        #1;
        chk("stall_release_ready", {31'd0, id_ready}, 32'd1);
        chk("stall_cnt_2", {16'd0, hazard_cnt}, 32'd2);
        step();
        id_valid = 1'b0; mwb_wr_en = 1'b0;

        // Same load match on rt of an I-type is not a source use.
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_wr_reg = 5'd2;
        issue(itype(6'h08, 5'd1, 5'd2, 16'h0001), 32'd9, 32'h2222, mk(32'd9, 32'd1, 4'd0, 1'b1, 5'd2, 1'b0));
        chk("itype_no_stall_cnt", {16'd0, hazard_cnt}, 32'd2);
        exm_wr_en = 1'b0; exm_is_load = 1'b0;
        step();
        step();

        // Back-pressure hold for three cycles.
        ex_ready = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'h31, 32'h32, mk(32'h31, 32'h32, 4'd1, 1'b1, 5'd3, 1'b0));
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", {31'd0, ex_valid}, 32'd1);
            chk("hold_ready", {31'd0, id_ready}, 32'd0);
            chk("hold_a", ex_a, 32'h31);
            chk("hold_b", ex_b, 32'h32);
            step();
        end
        ex_ready = 1'b1;
        step();

        // Flush during a hold: held instruction and incoming one are both dropped.
        ex_ready = 1'b0;
        id_instr = rtype(5'd1, 5'd2, 5'd9, 6'h20); rs_data = 32'h99; id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        #1;
        chk("flush_pre_valid", {31'd0, ex_valid}, 32'd1);
        step();
        flush = 1'b1; id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd4, 6'h20);
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_wr_reg = 5'd1;
        #1;
        chk("flush_ready", {31'd0, id_ready}, 32'd0);
        step();
        flush = 1'b0; id_valid = 1'b0; exm_wr_en = 1'b0; exm_is_load = 1'b0; ex_ready = 1'b1;
        #1;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_no_count", {16'd0, hazard_cnt}, 32'd2);
        step();
        step();

        // Asynchronous reset in the middle of a held transfer.
        ex_ready = 1'b0;
        id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); rs_data = 32'h55; rt_data = 32'h66; id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        #1;
        chk("pre_reset_a", ex_a, 32'h55);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst_a", ex_a, 32'd0);
        chk("async_rst_b", ex_b, 32'd0);
        chk("async_rst_misc", {20'd0, ex_alu_sel, ex_wr_en, ex_wr_reg, ex_illegal}, 32'd0);
        chk("async_rst_cnt", {16'd0, hazard_cnt}, 32'd0);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        #1;
        chk("post_reset_valid", {31'd0, ex_valid}, 32'd0);
        step();
        chk("post_reset_valid2", {31'd0, ex_valid}, 32'd0);
        step();
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
